// File: rtl/vga_timing_pkg.sv
// Shared types and standard mode constants for the VGA raster timing generator.
package vga_timing_pkg;

    // Position of a counter within one axis of the raster.
    typedef enum logic [1:0] {
        REGION_ACTIVE = 2'd0,
        REGION_FP     = 2'd1,
        REGION_SYNC   = 2'd2,
        REGION_BP     = 2'd3
    } region_t;

    // Complete timing description of one video mode.
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96,  h_bp: 32'd48,
        v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,   v_bp: 32'd33,
        hs_pol:   1'b0,    vs_pol: 1'b0
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 32'd800, h_fp: 32'd40, h_sync: 32'd128, h_bp: 32'd88,
        v_active: 32'd600, v_fp: 32'd1,  v_sync: 32'd4,   v_bp: 32'd23,
        hs_pol:   1'b1,    vs_pol: 1'b1
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bus: pixel clock enable in, sync/enable/coordinates/strobes out.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          CE;
    logic          H_SYNC;
    logic          V_SYNC;
    logic          DE;
    logic [XW-1:0] PIX_X;
    logic [YW-1:0] PIX_Y;
    logic          LINE_START;
    logic          FRAME_START;

    // Timing generator side.
    modport master (
        input  CE,
        output H_SYNC, V_SYNC, DE, PIX_X, PIX_Y, LINE_START, FRAME_START
    );

    // Pixel pipeline / pin side.
    modport slave (
        output CE,
        input  H_SYNC, V_SYNC, DE, PIX_X, PIX_Y, LINE_START, FRAME_START
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus region decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter  int unsigned ACTIVE = 640,
    parameter  int unsigned FP     = 16,
    parameter  int unsigned SYNC   = 96,
    parameter  int unsigned BP     = 48,
    localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W      = $clog2(TOTAL)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         advance,
    output logic [W-1:0] cnt,
    output logic         wrap_c,
    output region_t      region_c
);

    localparam int unsigned FP_START   = ACTIVE;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned BP_START   = ACTIVE + FP + SYNC;

    // Terminal count reached on an advancing cycle.
    assign wrap_c = advance && (cnt == W'(TOTAL - 1));

    // Position counter, wraps to zero after the last position.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= wrap_c ? '0 : cnt + W'(1);
        end
    end

    // Region of the count currently held.
    always_comb begin
        region_c = REGION_BP;
        if (cnt < W'(FP_START)) begin
            region_c = REGION_ACTIVE;
        end else if (cnt < W'(SYNC_START)) begin
            region_c = REGION_FP;
        end else if (cnt < W'(BP_START)) begin
            region_c = REGION_SYNC;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_640X480_60.h_active,
    parameter int unsigned H_FP     = MODE_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = MODE_640X480_60.h_sync,
    parameter int unsigned H_BP     = MODE_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = MODE_640X480_60.v_active,
    parameter int unsigned V_FP     = MODE_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = MODE_640X480_60.v_sync,
    parameter int unsigned V_BP     = MODE_640X480_60.v_bp,
    parameter bit          HS_POL   = MODE_640X480_60.hs_pol,
    parameter bit          VS_POL   = MODE_640X480_60.vs_pol
) (
    input  logic             CLK,
    input  logic             RST,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);

    // Every region must be at least one unit wide for the decode to be meaningful.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
        $error("vga_timing_gen: all timing parameters must be greater than zero");
    end

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap_c;
    logic          v_wrap_c;
    region_t       h_region_c;
    region_t       v_region_c;
    logic          de_c;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .CLK      (CLK),
        .RST      (RST),
        .advance  (vga.CE),
        .cnt      (h_cnt),
        .wrap_c   (h_wrap_c),
        .region_c (h_region_c)
    );

    // Lines advance only on the pixel that ends a line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .CLK      (CLK),
        .RST      (RST),
        .advance  (h_wrap_c),
        .cnt      (v_cnt),
        .wrap_c   (v_wrap_c),
        .region_c (v_region_c)
    );

    assign de_c = (h_region_c == REGION_ACTIVE) && (v_region_c == REGION_ACTIVE);

    // Output stage: loads the decode of the current position on each pixel enable;
    // levels hold between enables, strobes last exactly one clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vga.H_SYNC      <= ~HS_POL;
            vga.V_SYNC      <= ~VS_POL;
            vga.DE          <= 1'b0;
            vga.PIX_X       <= '0;
            vga.PIX_Y       <= '0;
            vga.LINE_START  <= 1'b0;
            vga.FRAME_START <= 1'b0;
        end else begin
            vga.LINE_START  <= 1'b0;
            vga.FRAME_START <= 1'b0;
            if (vga.CE) begin
                vga.H_SYNC      <= (h_region_c == REGION_SYNC) ? HS_POL : ~HS_POL;
                vga.V_SYNC      <= (v_region_c == REGION_SYNC) ? VS_POL : ~VS_POL;
                vga.DE          <= de_c;
                vga.PIX_X       <= de_c ? h_cnt : '0;
                vga.PIX_Y       <= de_c ? v_cnt : '0;
                vga.LINE_START  <= (h_cnt == '0);
                vga.FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

    // The frame-end pixel must return both counters to the origin.
    frame_wrap_origin: assert property (@(posedge CLK) disable iff (RST)
        v_wrap_c |=> ((h_cnt == '0) && (v_cnt == '0)));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using two small modes of opposite sync polarity.
module tb_vga_timing_gen;

    // Mode A: 8/2/3/2 x 4/1/2/1, active-low syncs -> 15 clk lines, 120 clk frames
    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    // Mode B: 6/1/2/3 x 3/1/2/2, active-high syncs -> 12 clk lines, 96 clk frames
    localparam int B_HA = 6, B_HF = 1, B_HS = 2, B_HB = 3;
    localparam int B_VA = 3, B_VF = 1, B_VS = 2, B_VB = 2;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] px;
        logic [2:0] py;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    vga_timing_gen_if #(.XW(4), .YW(3)) ifa ();
    vga_timing_gen_if #(.XW(4), .YW(3)) ifb ();

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .CLK (clk),
        .RST (rst),
        .vga (ifa)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .CLK (clk),
        .RST (rst),
        .vga (ifb)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   drv_done = 1'b0;
    bit   meas = 1'b0;
    int   ce_div = 1;
    exp_t qa[$];
    exp_t qb[$];

    // reference model state
    int   ma_h = 0, ma_v = 0, mb_h = 0, mb_v = 0;
    exp_t ma_e, mb_e;

    // period measurement state
    int a_ls_prev, a_fs_prev, a_de_n, a_hs_n, a_vs_n;
    int b_ls_prev, b_fs_prev, b_de_n, b_hs_n, b_vs_n;
    bit a_ls_seen, a_fs_seen, b_ls_seen, b_fs_seen;

    task automatic check_int(input string nm, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, req);
        end
    endtask

    task automatic check_exp(input string nm, input exp_t got, input exp_t req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     nm, cyc, got.hs, got.vs, got.de, got.px, got.py, got.ls, got.fs,
                     req.hs, req.vs, req.de, req.px, req.py, req.ls, req.fs);
        end
    endtask

    // Predicts outputs after the coming edge from the mode description and the edge inputs.
    task automatic model_step(input bit r, input bit c,
                              input int ha, input int hf, input int hsw, input int hb,
                              input int va, input int vf, input int vsw, input int vb,
                              input bit hpol, input bit vpol,
                              inout int h, inout int v, inout exp_t e);
        bit in_de;
        if (r) begin
            h = 0; v = 0;
            e.hs = ~hpol; e.vs = ~vpol; e.de = 1'b0;
            e.px = 4'd0;  e.py = 3'd0;  e.ls = 1'b0; e.fs = 1'b0;
        end else if (c) begin
            in_de = (h < ha) && (v < va);
            e.de = in_de;
            e.px = in_de ? 4'(h) : 4'd0;
            e.py = in_de ? 3'(v) : 3'd0;
            e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hpol : ~hpol;
            e.vs = (v >= va + vf && v < va + vf + vsw) ? vpol : ~vpol;
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
            h++;
            if (h == ha + hf + hsw + hb) begin
                h = 0;
                v++;
                if (v == va + vf + vsw + vb) v = 0;
            end
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
    endtask

    // Drive one clock's inputs, queue the predicted responses, then move to the next falling edge.
    task automatic step(input bit r, input bit c);
        rst    = r;
        ifa.CE = c;
        ifb.CE = c;
        model_step(r, c, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0, ma_h, ma_v, ma_e);
        qa.push_back(ma_e);
        model_step(r, c, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1, mb_h, mb_v, mb_e);
        qb.push_back(mb_e);
        @(negedge clk);
    endtask

    // Strobe spacing and per-line / per-frame level counts, scaled by the CE divide ratio.
    task automatic meas_chk(input string nm, input bit ls, input bit fs, input bit de,
                            input bit hs_on, input bit vs_on,
                            input int lp, input int fp, input int dec, input int hsc, input int vsc,
                            inout int ls_prev, inout int fs_prev, inout int de_n,
                            inout int hs_n, inout int vs_n, inout bit ls_seen, inout bit fs_seen);
        if (!meas) begin
            ls_seen = 1'b0;
            fs_seen = 1'b0;
            return;
        end
        if (ls) begin
            if (ls_seen) begin
                check_int({nm, "_line_period"}, cyc - ls_prev, lp * ce_div);
                check_int({nm, "_hsync_width"}, hs_n, hsc * ce_div);
            end
            ls_prev = cyc; hs_n = 0; ls_seen = 1'b1;
        end
        if (hs_on) hs_n++;
        if (fs) begin
            if (fs_seen) begin
                check_int({nm, "_frame_period"}, cyc - fs_prev, fp * ce_div);
                check_int({nm, "_de_per_frame"}, de_n, dec * ce_div);
                check_int({nm, "_vsync_per_frame"}, vs_n, vsc * ce_div);
            end
            fs_prev = cyc; de_n = 0; vs_n = 0; fs_seen = 1'b1;
        end
        if (de) de_n++;
        if (vs_on) vs_n++;
    endtask

    // Monitor: one sample per clock, just after the rising edge.
    initial begin
        exp_t ga, gb, ea, eb;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ga.hs = ifa.H_SYNC; ga.vs = ifa.V_SYNC; ga.de = ifa.DE;
            ga.px = ifa.PIX_X;  ga.py = ifa.PIX_Y;  ga.ls = ifa.LINE_START; ga.fs = ifa.FRAME_START;
            gb.hs = ifb.H_SYNC; gb.vs = ifb.V_SYNC; gb.de = ifb.DE;
            gb.px = ifb.PIX_X;  gb.py = ifb.PIX_Y;  gb.ls = ifb.LINE_START; gb.fs = ifb.FRAME_START;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_exp("dut_a_outputs", ga, ea);
            end else if (!drv_done) begin
                check_int("dut_a_scoreboard_underflow", 0, 1);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_exp("dut_b_outputs", gb, eb);
            end else if (!drv_done) begin
                check_int("dut_b_scoreboard_underflow", 0, 1);
            end
            meas_chk("a", ga.ls, ga.fs, ga.de, ga.hs == 1'b0, ga.vs == 1'b0,
                     15, 120, 32, 3, 30,
                     a_ls_prev, a_fs_prev, a_de_n, a_hs_n, a_vs_n, a_ls_seen, a_fs_seen);
            meas_chk("b", gb.ls, gb.fs, gb.de, gb.hs == 1'b1, gb.vs == 1'b1,
                     12, 96, 18, 2, 24,
                     b_ls_prev, b_fs_prev, b_de_n, b_hs_n, b_vs_n, b_ls_seen, b_fs_seen);
        end
    end

    // Stimulus
    initial begin
        int n;
        rst = 1'b1;
        ifa.CE = 1'b0;
        ifb.CE = 1'b0;
        ma_e = '0;
        mb_e = '0;

        // reset held while CE toggles
        for (int i = 0; i < 6; i++) step(1'b1, i[0] == 1'b0);
        check_int("rst_a_hsync", int'(ifa.H_SYNC), 1);
        check_int("rst_a_vsync", int'(ifa.V_SYNC), 1);
        check_int("rst_a_de", int'(ifa.DE), 0);
        check_int("rst_b_hsync", int'(ifb.H_SYNC), 0);
        check_int("rst_b_vsync", int'(ifb.V_SYNC), 0);

        // continuous pixel enable: three frames of mode A
        meas = 1'b1;
        ce_div = 1;
        for (int i = 0; i < 360; i++) step(1'b0, 1'b1);

        // pixel enable every other clock
        meas = 1'b0;
        ce_div = 2;
        for (int i = 0; i < 800; i++) begin
            if (i == 4) meas = 1'b1;
            step(1'b0, i[0] == 1'b0);
        end
        meas = 1'b0;

        // move to a known mid-frame pixel of mode A
        n = 0;
        while (!(ifa.DE == 1'b1 && ifa.PIX_Y == 3'd2 && ifa.PIX_X == 4'd5) && n < 300) begin
            step(1'b0, 1'b1);
            n++;
        end
        check_int("seek_midframe_within_bound", int'(n < 300), 1);

        // asynchronous reset mid-frame
        rst = 1'b1;
        #1;
        check_int("async_rst_a_de", int'(ifa.DE), 0);
        check_int("async_rst_a_pix_x", int'(ifa.PIX_X), 0);
        check_int("async_rst_a_pix_y", int'(ifa.PIX_Y), 0);
        check_int("async_rst_a_hsync", int'(ifa.H_SYNC), 1);
        check_int("async_rst_b_hsync", int'(ifb.H_SYNC), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // first enabled edge after release decodes the origin
        step(1'b0, 1'b1);
        check_int("release_a_frame_start", int'(ifa.FRAME_START), 1);
        check_int("release_a_de", int'(ifa.DE), 1);
        check_int("release_a_pix_x", int'(ifa.PIX_X), 0);
        check_int("release_a_pix_y", int'(ifa.PIX_Y), 0);
        check_int("release_b_frame_start", int'(ifb.FRAME_START), 1);

        // strobe drops on a disabled clock while levels hold
        step(1'b0, 1'b0);
        check_int("ce_low_a_frame_start", int'(ifa.FRAME_START), 0);
        check_int("ce_low_a_line_start", int'(ifa.LINE_START), 0);
        check_int("ce_low_a_de_hold", int'(ifa.DE), 1);

        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

        drv_done = 1'b1;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 4) begin
            @(negedge clk);
            n++;
        end
        check_int("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
